// File: rtl/prio_encode_rr_pkg.sv
// rtl/prio_encode_rr_pkg.sv - shared mode constants and width helper for the priority encoder
package prio_encode_rr_pkg;

    localparam logic [1:0] MODE_MSB = 2'd0;
    localparam logic [1:0] MODE_LSB = 2'd1;
    localparam logic [1:0] MODE_RR  = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - combinational N-bit winner selector (MSB, LSB or round-robin from ptr)
module prio_pick
    import prio_encode_rr_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] x,
    input  logic [1:0]   mode,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         hit
);

    logic [N-1:0] rot;
    int           msb_i;
    int           lsb_i;
    int           rr_off;
    int           rr_sum;
    int           j;

    always_comb begin
        rot    = '0;
        msb_i  = 0;
        lsb_i  = 0;
        rr_off = 0;
        j      = 0;
        // rot[0] is channel ptr, so an LSB-first scan of rot walks ptr, ptr+1, ... with wrap
        for (int i = 0; i < N; i++) begin
            j = i + int'(ptr);
            if (j >= N) j = j - N;
            rot[i] = x[j];
        end
        for (int i = 0; i < N; i++) begin
            if (x[i]) msb_i = i;
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (x[i]) lsb_i = i;
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) rr_off = i;
        end
        rr_sum = rr_off + int'(ptr);
        if (rr_sum >= N) rr_sum = rr_sum - N;
        case (mode)
            MODE_LSB: idx = W'(lsb_i);
            MODE_RR:  idx = W'(rr_sum);
            default:  idx = W'(msb_i);
        endcase
        hit = |x;
    end

endmodule

// File: rtl/prio_encode_rr.sv
// rtl/prio_encode_rr.sv - registered priority encoder with popcount, RR pointer and ready/valid output
module prio_encode_rr
    import prio_encode_rr_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] x,
    input  logic [1:0]   mode,
    output logic [W-1:0] y,
    output logic [N-1:0] y_onehot,
    output logic         valid,
    input  logic         ready,
    output logic [W:0]   cnt
);

    logic [W-1:0] ptr;
    logic [W-1:0] idx;
    logic         hit;
    logic [W:0]   pop;
    logic [N-1:0] onehot;
    logic [W-1:0] ptr_next;
    logic         free;

    prio_pick #(.N(N), .W(W)) u_pick (
        .x    (x),
        .mode (mode),
        .ptr  (ptr),
        .idx  (idx),
        .hit  (hit)
    );

    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + {{W{1'b0}}, x[i]};
        end
        onehot   = {{(N-1){1'b0}}, 1'b1} << idx;
        // explicit wrap so non-power-of-two N never lands on an unused index
        ptr_next = (idx == W'(N - 1)) ? '0 : idx + W'(1);
        free     = !valid || ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y        <= '0;
            y_onehot <= '0;
            valid    <= 1'b0;
            cnt      <= '0;
            ptr      <= '0;
        end else if (free) begin
            if (en && hit) begin
                valid    <= 1'b1;
                y        <= idx;
                y_onehot <= onehot;
                cnt      <= pop;
                if (mode == MODE_RR) ptr <= ptr_next;
            end else begin
                valid    <= 1'b0;
                y        <= '0;
                y_onehot <= '0;
                cnt      <= '0;
            end
        end
    end

endmodule

// File: doc/prio_encode_rr.md
Name: prio_encode_rr

Overview:
Parametrised, registered successor to the 4-to-2 combinational encoder. It takes an N-bit request vector and produces the binary index and one-hot form of the winning bit, plus a valid flag and a popcount of asserted requests. It supports MSB-first, LSB-first and round-robin priority, with a ready/valid output stage. It sits between request sources (keys, IRQ lines, FIFO-not-empty flags) and a downstream consumer that may stall.

Parameters:
N, 8, request vector width; N >= 2, need not be a power of two
W, $clog2(N), index width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  capture enable; when 0, a free slot is loaded with the empty result
x  input  N  request vector; bit i set = request on channel i
mode  input  2  0 = MSB-first, 1 = LSB-first, 2 = round-robin, 3 = reserved (behaves as 0)
y  output  W  encoded index of winning request
y_onehot  output  N  one-hot form of y; all-zero when valid = 0
valid  output  1  y / y_onehot / cnt hold a result with at least one request
ready  input  1  downstream accepts the current result
cnt  output  W+1  number of set bits in the captured x

Behaviour:
- Reset (rst_n = 0, asynchronous): y = 0, y_onehot = 0, valid = 0, cnt = 0, internal RR pointer ptr = 0. Release is synchronous to clk.
- Slot free condition: free = !valid || ready.
- Latency: one cycle. The registers load on the rising edge where free = 1. There is no combinational path from x to the outputs.
- Load, en = 1, x != 0:
  - valid <= 1; y <= winner; y_onehot <= 1 << winner; cnt <= popcount(x).
- Load, en = 1, x == 0: valid <= 0, y <= 0, y_onehot <= 0, cnt <= 0.
- Load, en = 0: same as x == 0. The outputs are cleared and ptr is unchanged.
- Stall (valid = 1, ready = 0): y, y_onehot, cnt, valid and ptr all hold. x, en and mode are ignored.
- Winner selection:
  - MSB-first: highest set index (same rule as the 4-to-2 for-loop encoder).
  - LSB-first: lowest set index.
  - Round-robin: first set index found scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- RR pointer update:
  - Only on a load with mode = 2, en = 1 and x != 0: ptr <= (winner + 1) mod N. For N not a power of two, wrap N-1 -> 0 explicitly.
  - All other loads and stalls leave ptr unchanged.
- Mode changes take effect at the next load; ptr is not reset by a mode change.
- Simultaneous ready = 1 and new request while valid = 1 (back-to-back): the new result replaces the old in the same edge, so full throughput is one result per cycle.
- Reset asserted mid-stall: the outputs clear immediately and the held result is dropped.
- Width rules: cnt is W+1 bits so that the all-ones vector (N) fits. y is zero-extended from the loop index with no truncation warnings.

Decomposition:
- Shared package holds:
  - mode constants MODE_MSB = 2'd0, MODE_LSB = 2'd1, MODE_RR = 2'd2
  - a clog2 helper function, for Verilog-2001 builds
- One natural sub-module, prio_pick: a purely combinational N-bit selector.
  - Inputs: x, mode, ptr. Outputs: idx, hit.
  - Implementation: a for-loop scan, with RR done by rotating x by ptr, scanning LSB-first, then adding ptr mod N.
- The top level holds the output registers, the ptr register, popcount and handshake logic.

Test Plan:
- Reset and basic MSB, N=8: rst_n low for 2 cycles gives all outputs 0. Then mode=0, en=1, ready=1, x=8'b0010_0110 -> next cycle y=5, y_onehot=8'h20, cnt=3, valid=1.
- LSB and zero input, N=8: mode=1, x=8'b0010_0110 -> y=1, y_onehot=8'h02. Next x=0 -> valid=0, y=0, cnt=0. en=0 with x=8'hFF -> valid=0, cnt=0.
- Round-robin fairness, N=8: mode=2, x=8'h81 held for 4 accepted cycles -> y sequence 0, 7, 0, 7, and ptr goes 1, 0, 1, 0. x=8'hFF for 9 cycles -> y = 0..7 then 0, with cnt=8 each cycle.
- Backpressure: valid=1, y=3, then ready=0 for 3 cycles while x changes to 8'h40 -> outputs and ptr frozen at y=3. ready=1 -> next cycle y=6.
- Non-power-of-two, N=5, W=3: mode=2, x=5'b10001, ptr after y=4 wraps to 0 (not 5). x=5'b11111 -> cnt=5 (3'b101 fits in W+1=4 bits).
- Async reset mid-stream: assert rst_n low between clock edges while valid=1 -> valid, y and ptr go to 0 without waiting for clk. After release, the first RR grant for x=8'hFF is y=0.
